// File: rtl/button_event_pkg.sv
// Shared types and constants for the button event block.
// The FSM state encoding lives here along with the clock rate used to size event timing.
package button_event_pkg;

  localparam int CLK_HZ = 10000000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    LONG    = 2'd2,
    LOCKOUT = 2'd3
  } state_e;

endpackage

// File: rtl/button_event_timer.sv
// Up-counter with synchronous clear and enable.
// Raises tc when the count reaches limit-1, and wraps back to zero on that cycle.
module event_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = en_i && !clr_i && (cnt_q == limit_i - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into registered press, release, long-press and repeat strobes.
// It also drives a held level and a wrapping press counter.
module button_event
  import button_event_pkg::*;
#(
  parameter int ACTIVE_HIGH   = 1,
  parameter int LONG_CYCLES   = CLK_HZ,
  parameter int REPEAT_CYCLES = CLK_HZ / 5,
  parameter int CNT_W         = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_in,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  state_e     state_q;
  logic       press_q;
  logic       release_q;
  logic       long_q;
  logic       repeat_q;
  logic       held_q;
  logic [7:0] count_q;

  logic             p;
  logic             timerEn;
  logic             timerTc;
  logic [CNT_W-1:0] timerLimit;

  assign p = (ACTIVE_HIGH != 0) ? button_in : ~button_in;

  // The timer runs only while pressed in a timed state. Because tc is gated by enable,
  // a release on the threshold edge suppresses the long or repeat strobe.
  assign timerEn    = p && ((state_q == PRESS) || ((state_q == LONG) && (REPEAT_CYCLES != 0)));
  assign timerLimit = (state_q == LONG) ? CNT_W'(REPEAT_CYCLES) : CNT_W'(LONG_CYCLES);

  event_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (!timerEn),
    .en_i   (timerEn),
    .limit_i(timerLimit),
    .tc_o   (timerTc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= p ? LOCKOUT : IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= p && (state_q != LOCKOUT);
      unique case (state_q)
        IDLE: begin
          if (p) begin
            state_q <= PRESS;
            press_q <= 1'b1;
            count_q <= count_q + 8'd1;
          end
        end
        PRESS: begin
          if (!p) begin
            state_q   <= IDLE;
            release_q <= 1'b1;
          end else if (timerTc) begin
            state_q <= LONG;
            long_q  <= 1'b1;
          end
        end
        LONG: begin
          if (!p) begin
            state_q   <= IDLE;
            release_q <= 1'b1;
          end else if (timerTc) begin
            repeat_q <= 1'b1;
          end
        end
        LOCKOUT: begin
          if (!p) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;
  assign press_count   = count_q;

endmodule
